// File: rtl/umd_pkg.sv
// rtl/umd_pkg.sv - shared types and helpers for the mul/div sequencer
package umd_pkg;

    // Operation codes follow the M-extension funct3 field.
    typedef enum logic [2:0] {
        UMD_MUL    = 3'b000,
        UMD_MULH   = 3'b001,
        UMD_MULHSU = 3'b010,
        UMD_MULHU  = 3'b011,
        UMD_DIV    = 3'b100,
        UMD_DIVU   = 3'b101,
        UMD_REM    = 3'b110,
        UMD_REMU   = 3'b111
    } umd_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } umd_state_e;

    function automatic logic is_div(umd_op_e op);
        return op[2];
    endfunction

    // Iteration counter width: must hold WORD_SIZE itself (early-out preload of a zero dividend).
    function automatic int umd_cnt_width(int word_size);
        return $clog2(word_size) + 1;
    endfunction

endpackage

// File: rtl/umd_div_step.sv
// rtl/umd_div_step.sv - one restoring shift-subtract division iteration
// Ports: rem/quo (current partial remainder and dividend/quotient shift register),
//        divisor, rem_next/quo_next (values after one iteration). Purely combinational.
module umd_div_step #(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] rem,
    input  logic [WORD_SIZE-1:0] quo,
    input  logic [WORD_SIZE-1:0] divisor,
    output logic [WORD_SIZE-1:0] rem_next,
    output logic [WORD_SIZE-1:0] quo_next
);

    logic [WORD_SIZE:0] shifted;
    logic [WORD_SIZE:0] diff;

    // rem < divisor always holds, so the shifted value fits in WORD_SIZE+1 bits.
    assign shifted = {rem, quo[WORD_SIZE-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        if (!diff[WORD_SIZE]) begin
            rem_next = diff[WORD_SIZE-1:0];
            quo_next = {quo[WORD_SIZE-2:0], 1'b1};
        end else begin
            rem_next = shifted[WORD_SIZE-1:0];
            quo_next = {quo[WORD_SIZE-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/umd_seq.sv
// rtl/umd_seq.sv - multicycle mul/div sequencer with M-extension corner cases
// Ports: clk, rst_n (sync, active-low); valid_i/ready_o issue handshake with
//        operator_i, operand_a_i, operand_b_i; flush_i aborts; valid_o/ready_i
//        result handshake with result_o; busy_o while not idle.
// Optional macro UMD_SEQ_EARLY_OUT_EN: skip leading-zero iterations of the dividend.
module umd_seq
    import umd_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [2:0]           operator_i,
    input  logic [WORD_SIZE-1:0] operand_a_i,
    input  logic [WORD_SIZE-1:0] operand_b_i,
    input  logic                 flush_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WORD_SIZE-1:0] result_o,
    output logic                 busy_o
);

    localparam int W     = WORD_SIZE;
    localparam int CNT_W = umd_cnt_width(WORD_SIZE);

    umd_state_e       state_q, state_d;
    umd_op_e          op_in, op_q;
    logic [W-1:0]     a_q, b_q, rem_q, res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q, neg_rem_q;

    logic             accept;
    logic             signed_div, a_neg, b_neg;
    logic [W-1:0]     abs_a, abs_b;
    logic             div_zero, div_ovf, corner;
    logic [W-1:0]     corner_res;
    logic [CNT_W-1:0] cnt_init;
    logic [W-1:0]     dividend_init;
    logic             dividend_done;

    assign op_in   = umd_op_e'(operator_i);
    assign ready_o = (state_q == S_IDLE) && !flush_i;
    assign accept  = valid_i && ready_o;
    assign valid_o = (state_q == S_DONE);
    assign busy_o  = (state_q != S_IDLE);
    assign result_o = res_q;

    // Divide operand preparation, evaluated on the issue-side inputs.
    assign signed_div = !operator_i[0];
    assign a_neg      = signed_div && operand_a_i[W-1];
    assign b_neg      = signed_div && operand_b_i[W-1];
    assign abs_a      = a_neg ? -operand_a_i : operand_a_i;
    assign abs_b      = b_neg ? -operand_b_i : operand_b_i;
    assign div_zero   = (operand_b_i == '0);
    assign div_ovf    = signed_div && (operand_a_i == {1'b1, {(W-1){1'b0}}}) && (operand_b_i == '1);
    assign corner     = div_zero || div_ovf;

    always_comb begin
        corner_res = '0;
        if (operator_i[1]) corner_res = div_zero ? operand_a_i : '0;
        else               corner_res = div_zero ? '1 : operand_a_i;
    end

`ifdef UMD_SEQ_EARLY_OUT_EN
    function automatic logic [CNT_W-1:0] lzc(input logic [W-1:0] v);
        lzc = CNT_W'(W);
        for (int i = 0; i < W; i++)
            if (v[i]) lzc = CNT_W'(W - 1 - i);
    endfunction

    // Leading zeros of the dividend can never produce quotient bits, so skip them.
    assign cnt_init      = lzc(abs_a);
    assign dividend_init = abs_a << cnt_init;
    assign dividend_done = (abs_a == '0);
`else
    assign cnt_init      = '0;
    assign dividend_init = abs_a;
    assign dividend_done = 1'b0;
`endif

    // Multiplier: extend each operand to 2W per its signedness; the low 2W bits
    // of the product are then correct for every combination.
    logic         a_sgn, b_sgn;
    logic [2*W-1:0] a_ext, b_ext, product;
    logic [W-1:0] mul_res;

    assign a_sgn   = (op_q == UMD_MULH) || (op_q == UMD_MULHSU);
    assign b_sgn   = (op_q == UMD_MULH);
    assign a_ext   = {{W{a_sgn && a_q[W-1]}}, a_q};
    assign b_ext   = {{W{b_sgn && b_q[W-1]}}, b_q};
    assign product = a_ext * b_ext;
    assign mul_res = (op_q == UMD_MUL) ? product[W-1:0] : product[2*W-1:W];

    // Divider datapath: a_q doubles as the dividend/quotient shift register.
    logic [W-1:0] rem_nx, quo_nx, quo_fix, rem_fix;

    umd_div_step #(.WORD_SIZE(W)) u_div_step (
        .rem      (rem_q),
        .quo      (a_q),
        .divisor  (b_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    assign quo_fix = neg_quo_q ? -a_q : a_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!is_div(op_in))  state_d = S_MUL;
                    else if (corner)     state_d = S_DONE;
                    else if (dividend_done) state_d = S_FIX;
                    else                 state_d = S_DIV;
                end
            end
            S_MUL:  state_d = S_DONE;
            S_DIV:  if (cnt_q == CNT_W'(W - 1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= UMD_MUL;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q      <= op_in;
                        rem_q     <= '0;
                        cnt_q     <= cnt_init;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (is_div(op_in)) begin
                            a_q <= dividend_init;
                            b_q <= abs_b;
                            if (corner) res_q <= corner_res;
                        end else begin
                            a_q <= operand_a_i;
                            b_q <= operand_b_i;
                        end
                    end
                end
                S_MUL: if (!flush_i) res_q <= mul_res;
                S_DIV: begin
                    rem_q <= rem_nx;
                    a_q   <= quo_nx;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIX: if (!flush_i) res_q <= op_q[1] ? rem_fix : quo_fix;
                default: ;
            endcase
        end
    end

endmodule
